// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue sequencer: register-file reads, ALU operand staging, write-back
// One instruction in flight; fixed five-cycle IDLE/READ_A/READ_B/EXEC/WB sequence.
module alu_issue_ctrl #(
  parameter int REG_AW = 3,
  parameter int DW     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [REG_AW-1:0] reg_raddr,
  input  logic [DW-1:0]     reg_rdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DW-1:0]     reg_wdata,
  output logic [DW-1:0]     alu_operand1,
  output logic [DW-1:0]     alu_operand2,
  output logic [2:0]        alu_operation,
  input  logic [DW-1:0]     alu_result,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    EXEC,
    WB
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [REG_AW-1:0]   rd_q, rs1_q, rs2_q;
  logic                imm_en_q;
  logic [5:0]          imm_q;
  logic [DW-1:0]       opa_q, opb_q;
  logic [DW-1:0]       imm_ext;
  logic                accept;

  assign accept  = in_valid & in_ready;
  assign imm_ext = {{(DW-6){imm_q[5]}}, imm_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= in_instr[15:13];
        rd_q     <= in_instr[12:10];
        rs1_q    <= in_instr[9:7];
        imm_en_q <= in_instr[6];
        rs2_q    <= in_instr[5:3];
        imm_q    <= in_instr[5:0];
      end
      // Read port is registered: rs1 data arrives in READ_B, rs2 data in EXEC.
      if (state == READ_B) begin
        opa_q <= reg_rdata;
      end
      if (state == EXEC) begin
        if (imm_en_q)
          opb_q <= imm_ext;
        else if (op_q == 3'b111)
          opb_q <= '0;
        else
          opb_q <= reg_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    reg_raddr = '0;
    case (state)
      IDLE:   if (in_valid) state_nxt = READ_A;
      READ_A: begin
        reg_raddr = rs1_q;
        state_nxt = READ_B;
      end
      READ_B: begin
        reg_raddr = rs2_q;
        state_nxt = EXEC;
      end
      EXEC:   state_nxt = WB;
      WB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign reg_we        = (state == WB);
  assign done          = (state == WB);
  assign reg_waddr     = rd_q;
  assign reg_wdata     = alu_result;
  assign alu_operand1  = opa_q;
  assign alu_operand2  = opb_q;
  assign alu_operation = op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  reg_raddr;
  logic [15:0] reg_rdata;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [15:0] alu_operand1;
  logic [15:0] alu_operand2;
  logic [2:0]  alu_operation;
  logic [15:0] alu_result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int exp_writes = 0;
  int dbl_done = 0;
  logic done_q = 1'b0;

  logic [15:0] rf [8];
  logic [15:0] ref_rf [8];
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;

  alu_issue_ctrl #(.REG_AW(3), .DW(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .reg_raddr     (reg_raddr),
    .reg_rdata     (reg_rdata),
    .reg_we        (reg_we),
    .reg_waddr     (reg_waddr),
    .reg_wdata     (reg_wdata),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] nb;
    nb = -b;
    case (op)
      3'b000:  return b[15] ? (a >> nb) : (a << b);
      3'b100:  return a + b;
      3'b101:  return a & b;
      3'b110:  return a | b;
      3'b111:  return ~a;
      default: return 16'h0000;
    endcase
  endfunction

  // Environment: the combinational ALU and a register file with a registered read port.
  assign alu_result = alu_fn(alu_operation, alu_operand1, alu_operand2);

  always @(posedge clk) begin
    if (pre_we)
      rf[pre_addr] <= pre_data;
    else if (reg_we)
      rf[reg_waddr] <= reg_wdata;
    reg_rdata <= rf[reg_raddr];
  end

  always @(posedge clk) begin
    if (reg_we) wr_count++;
    if (done && done_q) dbl_done++;
    done_q <= done;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic imm_en, input logic [5:0] low);
    return {op, rd, rs1, imm_en, low};
  endfunction

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_rf[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_we"}, reg_we, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_raddr"}, reg_raddr, 0);
    check({tag, "_waddr"}, reg_waddr, 0);
    check({tag, "_op1"}, alu_operand1, 0);
    check({tag, "_op2"}, alu_operand2, 0);
    check({tag, "_oper"}, alu_operation, 0);
  endtask

  // Called at a negedge; drives one instruction and checks every cycle up to write-back.
  task automatic issue(input logic [15:0] ins, input bit hold, input bit abort);
    logic [2:0]  op, rd, rs1, rs2;
    logic [5:0]  imm;
    logic [15:0] a, b, exp;
    int n;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs1 = ins[9:7];
    rs2 = ins[5:3];
    imm = ins[5:0];
    a   = ref_rf[rs1];
    if (ins[6])
      b = {{10{imm[5]}}, imm};
    else if (op == 3'b111)
      b = 16'h0000;
    else
      b = ref_rf[rs2];
    exp = alu_fn(op, a, b);

    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("c0_ready", in_ready, 1);
    in_valid = 1'b1;
    in_instr = ins;

    @(negedge clk);
    if (hold) in_instr = 16'($urandom);
    else in_valid = 1'b0;
    check("c1_ready", in_ready, 0);
    check("c1_busy", busy, 1);
    check("c1_raddr", reg_raddr, rs1);
    check("c1_we", reg_we, 0);

    @(negedge clk);
    check("c2_raddr", reg_raddr, rs2);
    check("c2_we", reg_we, 0);
    check("c2_ready", in_ready, 0);

    @(negedge clk);
    check("c3_op1", alu_operand1, a);
    check("c3_oper", alu_operation, op);
    check("c3_we", reg_we, 0);
    check("c3_done", done, 0);

    if (abort) begin
      reset_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(negedge clk);
      check("abort_we", reg_we, 0);
      check("abort_done", done, 0);
      in_valid = 1'b0;
      reset_n  = 1'b1;
      return;
    end

    @(negedge clk);
    check("c4_we", reg_we, 1);
    check("c4_done", done, 1);
    check("c4_waddr", reg_waddr, rd);
    check("c4_wdata", reg_wdata, exp);
    check("c4_op1", alu_operand1, a);
    check("c4_op2", alu_operand2, b);
    check("c4_ready", in_ready, 0);
    ref_rf[rd] = exp;
    exp_writes++;
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_instr = 16'h0000;
    pre_we   = 1'b0;
    pre_addr = 3'd0;
    pre_data = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
    preload(3'd1, 16'h00F0);
    preload(3'd2, 16'h0004);
    preload(3'd5, 16'hFFFF);
    preload(3'd6, 16'h0001);

    issue(mk(3'b000, 3'd3, 3'd1, 1'b0, {3'd2, 3'd0}), 1'b0, 1'b0);
    issue(mk(3'b000, 3'd4, 3'd1, 1'b1, 6'h3C), 1'b0, 1'b0);
    issue(mk(3'b100, 3'd5, 3'd5, 1'b0, {3'd6, 3'd0}), 1'b0, 1'b0);
    issue(mk(3'b111, 3'd7, 3'd1, 1'b0, 6'h00), 1'b1, 1'b0);
    issue(mk(3'b101, 3'd2, 3'd3, 1'b0, {3'd4, 3'd0}), 1'b1, 1'b0);
    issue(mk(3'b110, 3'd0, 3'd1, 1'b0, {3'd2, 3'd0}), 1'b0, 1'b1);
    issue(mk(3'b110, 3'd0, 3'd1, 1'b0, {3'd2, 3'd0}), 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("write_count", wr_count, exp_writes);
    check("double_done", dbl_done, 0);
    for (int i = 0; i < 8; i++) check("rf_final", rf[i], ref_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
